// File: rtl/prog_ctr.sv
// prog_ctr -- program counter and fetch sequencer for the 9-bit CPU.
//
// Produces the fetch address for the instruction ROM, which returns the
// machine code combinationally in the same cycle. Sequences
// IDLE -> RUN -> DONE, and handles stalls, sequential increment and taken
// branches. A 9-bit instruction cannot hold a full address, so branch
// targets come from a writable 2**L-entry lookup table indexed by br_idx.
//
// Optional build macro: REL_BRANCH_EN
//   When defined, adds rel_en/rel_off. A taken branch with rel_en = 1
//   moves the PC by the sign-extended 6-bit offset instead of reading the
//   LUT.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   begin / re-begin execution (honoured in IDLE, DONE)
//   halt_req     in   stop execution (decoded halt instruction)
//   stall        in   hold the PC this cycle
//   br_en        in   current instruction is a branch
//   br_cond      in   branch condition; taken = br_en & br_cond
//   br_idx       in   [L] LUT index of the branch target
//   lut_we       in   LUT write enable
//   lut_waddr    in   [L] LUT write index
//   lut_wdata    in   [D] LUT write data (absolute target)
//   rel_en       in   (REL_BRANCH_EN) taken branch is PC-relative
//   rel_off      in   [6] (REL_BRANCH_EN) signed branch offset
//   prog_ctr_out out  [D] current fetch address
//   running      out  state == RUN
//   done         out  state == DONE
module prog_ctr #(
  parameter int unsigned D          = 12,
  parameter int unsigned L          = 5,
  parameter int unsigned START_ADDR = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         halt_req,
  input  logic         stall,
  input  logic         br_en,
  input  logic         br_cond,
  input  logic [L-1:0] br_idx,
  input  logic         lut_we,
  input  logic [L-1:0] lut_waddr,
  input  logic [D-1:0] lut_wdata,
`ifdef REL_BRANCH_EN
  input  logic         rel_en,
  input  logic [5:0]   rel_off,
`endif
  output logic [D-1:0] prog_ctr_out,
  output logic         running,
  output logic         done
);

  localparam int unsigned LUT_N = 2 ** L;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [D-1:0]   pc, pc_nxt;
  logic [D-1:0]   lut [LUT_N];
  logic           taken;
  logic [D-1:0]   br_tgt;

  assign taken = br_en & br_cond;

  // The LUT is read combinationally from its current contents, so a write
  // landing on the same edge as a taken branch to that index is not seen
  // by the branch: it takes the old entry.
`ifdef REL_BRANCH_EN
  logic [D-1:0] rel_ext;
  assign rel_ext = {{(D-6){rel_off[5]}}, rel_off};
  assign br_tgt  = rel_en ? (pc + rel_ext) : lut[br_idx];
`else
  assign br_tgt  = lut[br_idx];
`endif

  // Branch-target LUT: writable in any state, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Next state / next PC. In RUN the first matching rule wins:
  // halt, stall, taken branch, increment. Halt discards a same-cycle branch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = D'(START_ADDR);
        end
      end
      RUN: begin
        if (halt_req)   state_nxt = DONE;
        else if (stall) pc_nxt    = pc;
        else if (taken) pc_nxt    = br_tgt;
        else            pc_nxt    = pc + 1'b1;  // wraps at 2**D silently
      end
      DONE: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = D'(START_ADDR);
        end
      end
      default: begin
        state_nxt = IDLE;
        pc_nxt    = '0;
      end
    endcase
  end

  assign prog_ctr_out = pc;
  assign running      = (state == RUN);
  assign done         = (state == DONE);

endmodule
